// File: rtl/scan_sequencer.sv
// Board scanner: walks squares 0..63, issues each own piece to the transmitter
// through a settle delay and a valid/ready handshake.
module scan_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       engine_color,
    output logic       ram_rd_en,
    output logic [5:0] ram_addr,
    input  logic [5:0] ram_rdata,
    output logic [5:0] piece_reg,
    output logic [5:0] pos_reg,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic       busy,
    output logic       done,
    output logic [6:0] piece_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        SETTLE,
        ISSUE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic       color_q, color_d;
    logic [5:0] piece_q, piece_d;
    logic [5:0] pos_q, pos_d;
    logic [6:0] count_q, count_d;
    logic [3:0] settle_q, settle_d;
    logic       own_piece;
    logic       last_sq;

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v >= 7'd64) ? 7'd64 : v + 7'd1;
    endfunction

    assign own_piece = (ram_rdata[4:0] != 5'd0) && (ram_rdata[5] == color_q);
    assign last_sq   = (idx_q == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 6'd0;
            color_q  <= 1'b0;
            piece_q  <= 6'd0;
            pos_q    <= 6'd0;
            count_q  <= 7'd0;
            settle_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            color_q  <= color_d;
            piece_q  <= piece_d;
            pos_q    <= pos_d;
            count_q  <= count_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        color_d  = color_q;
        piece_d  = piece_q;
        pos_d    = pos_q;
        count_d  = count_q;
        settle_d = settle_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    color_d = engine_color;
                    idx_d   = 6'd0;
                    count_d = 7'd0;
                    state_d = READ;
                end
            end
            READ: state_d = EVAL;
            EVAL: begin
                if (own_piece) begin
                    piece_d  = ram_rdata;
                    pos_d    = idx_q;
                    settle_d = 4'd0;
                    state_d  = SETTLE;
                end else if (last_sq) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = READ;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ISSUE;
                else settle_d = settle_q + 4'd1;
            end
            ISSUE: begin
                if (issue_ready) begin
                    count_d = sat_inc(count_q);
                    piece_d = 6'd0;
                    pos_d   = 6'd0;
                    if (last_sq) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides whatever the state decided, including a same-cycle handshake.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            piece_d = 6'd0;
            pos_d   = 6'd0;
            count_d = count_q;
            idx_d   = idx_q;
        end
    end

    assign ram_rd_en   = (state_q == READ);
    assign ram_addr    = idx_q;
    assign piece_reg   = piece_q;
    assign pos_reg     = pos_q;
    assign issue_valid = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign piece_count = count_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: table of board scans plus hand-written
// sequences for backpressure, abort, start-while-busy and mid-scan reset.
module tb_scan_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst, start, abort, engine_color, issue_ready;
    logic       ram_rd_en, issue_valid, busy, done;
    logic [5:0] ram_addr, ram_rdata, piece_reg, pos_reg;
    logic [6:0] piece_count;

    logic [5:0] board [64];
    logic [5:0] rdata_q = 6'd0;

    int n_checks = 0;
    int n_fail   = 0;

    scan_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .engine_color(engine_color), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .ram_rdata(ram_rdata), .piece_reg(piece_reg), .pos_reg(pos_reg),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .busy(busy),
        .done(done), .piece_count(piece_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_en) rdata_q <= board[ram_addr];
    assign ram_rdata = rdata_q;

    // Scan monitor: statistics of the current scan, cleared while idle.
    int         rd_cnt, addr_err, issue_cnt, settle_m, valid_cyc, stable_err;
    logic [5:0] exp_addr, iss_piece, iss_pos, prev_piece, prev_pos;
    logic       prev_valid;
    always @(posedge clk) begin
        if (!busy) begin
            rd_cnt = 0; addr_err = 0; issue_cnt = 0; settle_m = 0;
            valid_cyc = 0; stable_err = 0; exp_addr = 6'd0;
            iss_piece = 6'd0; iss_pos = 6'd0;
        end else begin
            if (ram_rd_en) begin
                if (ram_addr != exp_addr) addr_err++;
                exp_addr = exp_addr + 6'd1;
                rd_cnt++;
            end
            if (issue_valid) begin
                valid_cyc++;
                if (prev_valid && (piece_reg != prev_piece || pos_reg != prev_pos)) stable_err++;
            end
            if (piece_reg != 6'd0 && !issue_valid) settle_m++;
            if (issue_valid && issue_ready && !abort) begin
                issue_cnt++;
                iss_piece = piece_reg;
                iss_pos   = pos_reg;
            end
        end
        prev_valid = issue_valid && !issue_ready;
        prev_piece = piece_reg;
        prev_pos   = pos_reg;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 6'd0;
    endtask

    task automatic run_scan(output int cyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        logic       color;
        int         sq_a;
        logic [5:0] code_a;
        int         sq_b;
        logic [5:0] code_b;
        int         exp_cnt;
        logic [5:0] exp_piece;
        logic [5:0] exp_pos;
        int         exp_done;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int  cyc;
        int  k;
        bit  ok;

        vecs[0] = '{1'b1, 12, 6'b100010, 20, 6'b000001, 1, 6'b100010, 6'd12, 132};
        vecs[1] = '{1'b0, 12, 6'b100010, 20, 6'b000001, 1, 6'b000001, 6'd20, 132};
        vecs[2] = '{1'b1,  0, 6'b100001,  5, 6'b100011, 2, 6'b100011, 6'd5,  135};
        vecs[3] = '{1'b0,  0, 6'b100000,  1, 6'b000000, 0, 6'b000000, 6'd0,  129};
        vecs[4] = '{1'b0, 63, 6'b011111,  2, 6'b100111, 1, 6'b011111, 6'd63, 132};

        clear_board();
        rst = 1'b1; start = 1'b1; abort = 1'b1; engine_color = 1'b1; issue_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_piece", 32'(piece_reg), 32'd0);
        chk("rst_pos", 32'(pos_reg), 32'd0);
        chk("rst_count", 32'(piece_count), 32'd0);
        chk("rst_valid_done", 32'({issue_valid, done}), 32'd0);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);

        // Empty board: 64 reads, done at cycle 129, nothing issued.
        issue_ready = 1'b1;
        run_scan(cyc);
        chk("empty_done_cycle", 32'(cyc), 32'd129);
        chk("empty_reads", 32'(rd_cnt), 32'd64);
        chk("empty_addr_seq", 32'(addr_err), 32'd0);
        chk("empty_count", 32'(piece_count), 32'd0);
        chk("empty_valid_cycles", 32'(valid_cyc), 32'd0);
        @(negedge clk);
        chk("empty_done_width", 32'(done), 32'd0);
        chk("empty_idle", 32'(busy), 32'd0);

        for (int v = 0; v < 5; v++) begin
            clear_board();
            board[vecs[v].sq_a] = vecs[v].code_a;
            board[vecs[v].sq_b] = vecs[v].code_b;
            engine_color = vecs[v].color;
            issue_ready  = 1'b1;
            run_scan(cyc);
            chk($sformatf("vec%0d_done_cycle", v), 32'(cyc), 32'(vecs[v].exp_done));
            chk($sformatf("vec%0d_count", v), 32'(piece_count), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_issues", v), 32'(issue_cnt), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_piece", v), 32'(iss_piece), 32'(vecs[v].exp_piece));
            chk($sformatf("vec%0d_pos", v), 32'(iss_pos), 32'(vecs[v].exp_pos));
            chk($sformatf("vec%0d_reads", v), 32'(rd_cnt), 32'd64);
            chk($sformatf("vec%0d_addr_seq", v), 32'(addr_err), 32'd0);
            chk($sformatf("vec%0d_settle", v), 32'(settle_m), 32'(vecs[v].exp_cnt * S));
            @(negedge clk);
            chk($sformatf("vec%0d_done_width", v), 32'(done), 32'd0);
        end

        // Own piece on square 63 with the downstream stalled for 10 cycles.
        clear_board();
        board[63] = 6'b100101;
        engine_color = 1'b1; issue_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!issue_valid && k < 300) begin @(negedge clk); k++; end
        chk("bp_valid_seen", 32'(issue_valid), 32'd1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!issue_valid || piece_reg != 6'b100101 || pos_reg != 6'd63) ok = 1'b0;
        end
        chk("bp_hold", 32'(ok), 32'd1);
        chk("bp_stable", 32'(stable_err), 32'd0);
        issue_ready = 1'b1;
        @(negedge clk);
        issue_ready = 1'b0;
        chk("bp_done_next", 32'(done), 32'd1);
        chk("bp_valid_low", 32'(issue_valid), 32'd0);
        chk("bp_piece_clear", 32'(piece_reg), 32'd0);
        chk("bp_count", 32'(piece_count), 32'd1);
        chk("bp_valid_cycles", 32'(valid_cyc >= 11), 32'd1);
        @(negedge clk);
        chk("bp_idle", 32'(busy), 32'd0);

        // Start while scanning is ignored; abort beats a same-cycle handshake.
        clear_board();
        board[3] = 6'b100100;
        board[9] = 6'b101000;
        engine_color = 1'b1; issue_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("restart_ignored", 32'({ram_rd_en, ram_addr}), 32'({1'b1, 6'd1}));
        k = 0;
        while (!(issue_valid && pos_reg == 6'd9) && k < 300) begin @(negedge clk); k++; end
        chk("ab_reach_issue", 32'(issue_valid && pos_reg == 6'd9), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle", 32'(busy), 32'd0);
        chk("ab_piece", 32'(piece_reg), 32'd0);
        chk("ab_pos", 32'(pos_reg), 32'd0);
        chk("ab_valid", 32'(issue_valid), 32'd0);
        chk("ab_count", 32'(piece_count), 32'd1);
        ok = !done;
        repeat (3) begin @(negedge clk); if (done) ok = 1'b0; end
        chk("ab_no_done", 32'(ok), 32'd1);

        // Reset in the middle of a scan, then a clean rescan.
        clear_board();
        board[10] = 6'b100001;
        engine_color = 1'b1; issue_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(ram_rd_en && ram_addr == 6'd30) && k < 300) begin @(negedge clk); k++; end
        chk("rs_reach_30", 32'(ram_rd_en && ram_addr == 6'd30), 32'd1);
        chk("rs_count_pre", 32'(piece_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_outputs", 32'({busy, done, issue_valid, ram_rd_en}), 32'd0);
        chk("rs_regs", 32'({ram_addr, piece_reg, pos_reg, piece_count}), 32'd0);
        run_scan(cyc);
        chk("rs_done_cycle", 32'(cyc), 32'd132);
        chk("rs_addr_seq", 32'(addr_err), 32'd0);
        chk("rs_reads", 32'(rd_cnt), 32'd64);
        chk("rs_count", 32'(piece_count), 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles piece_reg/pos_reg are held stable before issue_valid rises; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, synchronous scan cancel.
REQ-006 SHALL have port engine_color, input, 1, side to move (1 = white, 0 = black), sampled with start.
REQ-007 SHALL have port ram_rd_en, output, 1, board RAM read strobe.
REQ-008 SHALL have port ram_addr, output, 6, square index 0..63.
REQ-009 SHALL have port ram_rdata, input, 6, board RAM piece code; valid the cycle after ram_rd_en.
REQ-010 SHALL have port piece_reg, output, 6, registered piece code driving the transmitter; bit5 = color, [4:0] = type, 00000 = empty.
REQ-011 SHALL have port pos_reg, output, 6, registered square of piece_reg.
REQ-012 SHALL have port issue_valid, output, 1, piece_reg/pos_reg settled and awaiting propagation.
REQ-013 SHALL have port issue_ready, input, 1, downstream propagation complete; handshake = issue_valid & issue_ready at a rising edge.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at normal scan completion.
REQ-016 SHALL have port piece_count, output, 7, own pieces issued in current or last scan.

Function
REQ-017 SHALL implement states IDLE, READ, EVAL, SETTLE, ISSUE, DONE.
REQ-018 IDLE: start=1 SHALL latch engine_color, clear idx and piece_count, and go to READ; start=0 stays.
REQ-019 READ: ram_rd_en=1, ram_addr=idx for exactly one cycle, then EVAL.
REQ-020 EVAL: if ram_rdata[4:0]!=0 and ram_rdata[5]==latched color, SHALL load piece_reg=ram_rdata, pos_reg=idx, go to SETTLE.
REQ-021 EVAL otherwise (empty or enemy): idx==63 -> DONE, else idx+1 -> READ; piece_reg stays 000000.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to ISSUE.
REQ-023 ISSUE: issue_valid=1 until handshake; piece_reg/pos_reg SHALL stay constant while issue_valid=1.
REQ-024 On handshake: piece_count+1, piece_reg and pos_reg cleared to 0, issue_valid low next cycle; idx==63 -> DONE, else idx+1 -> READ.
REQ-025 DONE: done=1 for one cycle, then IDLE; piece_count holds until next start.
REQ-026 piece_reg SHALL be 000000 in every state except SETTLE and ISSUE, so the transmitter outputs all zero.
REQ-027 idx SHALL never wrap; square 63 always terminates the scan.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next cycle: piece_reg/pos_reg/issue_valid cleared, no done pulse, piece_count holds.
REQ-030 abort and issue_ready in the same ISSUE cycle: abort wins, piece_count not incremented.
REQ-031 piece_count SHALL saturate at 64.

Reset
REQ-032 rst=1 SHALL force IDLE at the next edge, overriding start/abort: idx=0, piece_reg=0, pos_reg=0, piece_count=0, issue_valid=0, ram_rd_en=0, ram_addr=0, busy=0, done=0.
REQ-033 rst mid-scan SHALL discard the scan with no done pulse.

Verification
REQ-034 Empty board, start at edge 0 -> 64 READ strobes at addr 0..63, done exactly at cycle 129, piece_count=0, issue_valid never high.
REQ-035 engine_color=1, white pawn 000010|1 (6'b100010) at square 12, black knight (6'b000001) at 20, issue_ready=1 -> one issue with piece_reg=6'b100010, pos_reg=12 after SETTLE_CYCLES, piece_count=1.
REQ-036 Own piece at square 63, issue_ready held low 10 cycles -> issue_valid high 10+ cycles with stable outputs; after handshake, done next cycle.
REQ-037 abort during ISSUE with issue_ready=1 -> IDLE, piece_reg=0, no done, piece_count unchanged; start pulsed in READ -> ignored.
REQ-038 rst asserted mid-scan at square 30 -> all outputs at reset values next cycle; new start rescans from address 0.
